// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder sequencer, truncating, one datapath step per state.
// Define FP_ADD_SEQ_BARREL_EN for single-cycle align and normalize shifts.
module fp_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, DONE
  } state_t;

  state_t state, stateNext;

  logic [31:0] opA, opB, resReg;
  logic        sX, sY;
  logic [7:0]  eX, diff;
  logic [23:0] mX, mY;
  logic [24:0] sum;

  logic [7:0]  eA, eB, eDiff;
  logic [23:0] mA, mB;
  logic        swap;
  logic [24:0] addSum;

  logic [24:0] nSum;
  logic [7:0]  nExp;
  logic        nDone;
  logic [31:0] nRes;

`ifdef FP_ADD_SEQ_BARREL_EN
  logic [4:0] lz;

  function automatic logic [4:0] lzc(input logic [23:0] v);
    lzc = 5'd0;
    for (int i = 0; i < 24; i++)
      if (v[i]) lzc = 5'(23 - i);
  endfunction

  assign lz = lzc(sum[23:0]);
`endif

  assign eA = opA[30:23];
  assign eB = opB[30:23];
  assign mA = (eA != 8'd0) ? {1'b1, opA[22:0]} : 24'd0;
  assign mB = (eB != 8'd0) ? {1'b1, opB[22:0]} : 24'd0;
  assign swap = (eB > eA) || ((eB == eA) && (mB > mA));
  assign eDiff = swap ? (eB - eA) : (eA - eB);

  assign addSum = (sX == sY) ? ({1'b0, mX} + {1'b0, mY})
                             : ({1'b0, mX} - {1'b0, mY});

  // Normalize step; nDone marks the cycle that also packs the result.
  always_comb begin
    nSum  = sum;
    nExp  = eX;
    nDone = 1'b0;
    nRes  = 32'd0;
    if (sum[24]) begin
      nSum  = sum >> 1;
      nExp  = eX + 8'd1;
      nDone = 1'b1;
      if (eX >= 8'd254) nRes = {sX, 8'hFF, 23'd0};
      else              nRes = {sX, nExp, nSum[22:0]};
    end else if (sum[23]) begin
      nDone = 1'b1;
      nRes  = {sX, eX, sum[22:0]};
    end else begin
`ifdef FP_ADD_SEQ_BARREL_EN
      nDone = 1'b1;
      if (eX > {3'd0, lz}) begin
        nSum = sum << lz;
        nExp = eX - {3'd0, lz};
        nRes = {sX, nExp, nSum[22:0]};
      end
`else
      if (eX <= 8'd1) begin
        nDone = 1'b1;
      end else begin
        nSum  = sum << 1;
        nExp  = eX - 8'd1;
        nDone = nSum[23];
        nRes  = {sX, nExp, nSum[22:0]};
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (in_valid) stateNext = UNPACK;
      UNPACK: stateNext = ALIGN;
`ifdef FP_ADD_SEQ_BARREL_EN
      ALIGN:  stateNext = ADD;
`else
      ALIGN:  if (diff <= 8'd1) stateNext = ADD;
`endif
      ADD:    stateNext = (addSum == 25'd0) ? DONE : NORM;
      NORM:   if (nDone) stateNext = DONE;
      DONE:   if (out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opA    <= 32'd0;
      opB    <= 32'd0;
      resReg <= 32'd0;
      sX     <= 1'b0;
      sY     <= 1'b0;
      eX     <= 8'd0;
      diff   <= 8'd0;
      mX     <= 24'd0;
      mY     <= 24'd0;
      sum    <= 25'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            opA <= a;
            opB <= b;
          end
        end
        UNPACK: begin
          sX <= swap ? opB[31] : opA[31];
          sY <= swap ? opA[31] : opB[31];
          eX <= swap ? eB : eA;
          mX <= swap ? mB : mA;
          if (eDiff > 8'd25) begin
            mY   <= 24'd0;
            diff <= 8'd0;
          end else begin
            mY   <= swap ? mA : mB;
            diff <= eDiff;
          end
        end
        ALIGN: begin
`ifdef FP_ADD_SEQ_BARREL_EN
          mY   <= mY >> diff;
          diff <= 8'd0;
`else
          if (diff != 8'd0) begin
            mY   <= mY >> 1;
            diff <= diff - 8'd1;
          end
`endif
        end
        ADD: begin
          sum <= addSum;
          if (addSum == 25'd0) resReg <= 32'd0;
        end
        NORM: begin
          sum <= nSum;
          eX  <= nExp;
          if (nDone) resReg <= nRes;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign result    = resReg;

endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed cases, backpressure, reset abort and
// random operands against an arithmetic reference model.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [31:0] result;
  logic        outValid;
  logic        outReady = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_seq dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .in_valid(inValid),
    .in_ready(inReady),
    .result(result),
    .out_valid(outValid),
    .out_ready(outReady),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference: operands as integers, shifts as plain arithmetic.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output int lat);
    int ex, ey, mx, my, sx, sy, d, s, e, n, aC, nC, t;
    bit zero;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = (ex != 0) ? (int'(x[22:0]) + (1 << 23)) : 0;
    my = (ey != 0) ? (int'(y[22:0]) + (1 << 23)) : 0;
    sx = int'(x[31]);
    sy = int'(y[31]);
    if (ey > ex || (ey == ex && my > mx)) begin
      t = ex; ex = ey; ey = t;
      t = mx; mx = my; my = t;
      t = sx; sx = sy; sy = t;
    end
    d = ex - ey;
    if (d > 25) begin
      my = 0;
      d = 0;
    end
    aC = (d > 1) ? d : 1;
    my = my / (1 << d);
    s = (sx == sy) ? mx + my : mx - my;
    e = ex;
    n = 0;
    zero = (s == 0);
    r = 32'd0;
    if (zero) begin
      r = 32'd0;
    end else if (s >= (1 << 24)) begin
      s = s / 2;
      e = e + 1;
      n = 1;
      r = (e >= 255) ? {sx[0], 8'hFF, 23'd0} : {sx[0], e[7:0], s[22:0]};
    end else begin
      while (s < (1 << 23) && e > 0) begin
        s = s * 2;
        e = e - 1;
        n++;
      end
      r = (e == 0) ? 32'd0 : {sx[0], e[7:0], s[22:0]};
    end
    nC = (n > 1) ? n : 1;
`ifdef FP_ADD_SEQ_BARREL_EN
    aC = 1;
    nC = 1;
`endif
    lat = zero ? 2 + aC : 2 + aC + nC;
  endfunction

  task automatic runOp(input logic [31:0] x, input logic [31:0] y,
                       input string tag, input bit useConst,
                       input logic [31:0] constR);
    logic [31:0] expR;
    int expL, lat;
    bit busyOk, rdyOk;
    model(x, y, expR, expL);
    @(negedge clk);
    check({tag, " in_ready idle"}, 32'(inReady), 32'd1);
    a = x;
    b = y;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    lat = 0;
    busyOk = busy;
    rdyOk = !inReady;
    while (!outValid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      busyOk &= busy;
      rdyOk &= !inReady;
    end
    check({tag, " result"}, result, expR);
    if (useConst) check({tag, " result const"}, result, constR);
    check({tag, " latency"}, 32'(lat), 32'(expL));
    check({tag, " busy"}, 32'(busyOk), 32'd1);
    check({tag, " in_ready low"}, 32'(rdyOk), 32'd1);
    @(negedge clk);
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    check({tag, " out_valid drop"}, 32'(outValid), 32'd0);
    check({tag, " in_ready back"}, 32'(inReady), 32'd1);
  endtask

  logic [31:0] dirA [9] = '{32'h3F800000, 32'h40400000, 32'h3F800000,
                            32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
                            32'h00800001, 32'h4C800000, 32'h3F800000};
  logic [31:0] dirB [9] = '{32'h3F800000, 32'hBF800000, 32'h3A800000,
                            32'hBF7FFFFF, 32'hBF800000, 32'h7F7FFFFF,
                            32'h80800000, 32'h3F800000, 32'h00000001};
  logic [31:0] dirR [9] = '{32'h40000000, 32'h40000000, 32'h3F802000,
                            32'h34000000, 32'h00000000, 32'h7F800000,
                            32'h00000000, 32'h4C800000, 32'h3F800000};

  initial begin
    logic [31:0] held, expR, ra, rb;
    int expL, ea, eb;

    #2;
    check("rst in_ready", 32'(inReady), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_valid", 32'(outValid), 32'd0);
    check("rst result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      runOp(dirA[i], dirB[i], $sformatf("dir%0d", i), 1'b1, dirR[i]);

    // Backpressure: result held, new operands ignored.
    model(32'h40400000, 32'h3F800000, expR, expL);
    @(negedge clk);
    a = 32'h40400000;
    b = 32'h3F800000;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    for (int k = 0; k < 200 && !outValid; k++) @(posedge clk);
    #1 held = result;
    check("bp result", held, expR);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      check("bp held", result, held);
      check("bp in_ready", 32'(inReady), 32'd0);
      check("bp out_valid", 32'(outValid), 32'd1);
    end
    @(negedge clk);
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    check("bp release", 32'(outValid), 32'd0);
    check("bp idle", 32'(inReady), 32'd1);
    @(posedge clk);
    #1 check("bp no restart", 32'(busy), 32'd0);

    // Reset during ALIGN aborts the operation.
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h3A800000;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort out_valid", 32'(outValid), 32'd0);
    check("abort in_ready", 32'(inReady), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1 check("abort quiet", 32'(outValid), 32'd0);
    end
    runOp(32'h3F800000, 32'h3F800000, "after abort", 1'b1, 32'h40000000);

    // Random operands, biased toward close exponents for cancellation.
    for (int i = 0; i < 40; i++) begin
      ea = $urandom_range(100, 150);
      case ($urandom_range(0, 3))
        0: eb = ea;
        1: eb = ea - 30 + $urandom_range(0, 60);
        2: eb = ea + $urandom_range(0, 2) - 1;
        default: eb = 0;
      endcase
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      if (eb == ea && i % 2 == 0) rb[22:0] = ra[22:0] ^ 23'($urandom_range(0, 7));
      runOp(ra, rb, $sformatf("rnd%0d", i), 1'b0, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
